// File: rtl/match_pkg.sv
// Shared types and helpers for the multi-round match controller.
package match_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_INTRO,
    ST_BATTLE,
    ST_PAUSED,
    ST_ROUND_END,
    ST_MATCH_WIN,
    ST_MATCH_LOSE
  } stage_t;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_PLAYER = 2'd1;
  localparam logic [1:0] RES_NPC    = 2'd2;
  localparam logic [1:0] RES_DRAW   = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; stops at zero and reports it.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/match_control.sv
// Best-of-N match sequencer: countdown, timed rounds, pause, inter-round hold and scoring.
module match_control
  import match_pkg::*;
#(
  parameter int  ROUNDS_TO_WIN = 2,
  parameter int  INTRO_FRAMES  = 120,
  parameter int  ROUND_FRAMES  = 5400,
  parameter int  END_FRAMES    = 90,
  parameter int  HP_W          = 8,
  localparam int FW            = $clog2(max3(INTRO_FRAMES, ROUND_FRAMES, END_FRAMES) + 1)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Restart,
  input  logic            Fight,
  input  logic            Pause,
  input  logic            Player_Dead,
  input  logic            NPC_Dead,
  input  logic [HP_W-1:0] Player_HP,
  input  logic [HP_W-1:0] NPC_HP,
  output logic            start_l,
  output logic            intro_l,
  output logic            game_l,
  output logic            pause_l,
  output logic            round_end_l,
  output logic            win_l,
  output logic            lose_l,
  output logic            round_reset,
  output logic [7:0]      round_num,
  output logic [3:0]      player_wins,
  output logic [3:0]      npc_wins,
  output logic [1:0]      round_result,
  output logic [FW-1:0]   frames_left
);

  logic [1:0]    rst_sync;
  logic          core_rst_n;
  logic          fight_q, pause_q, fight_edge, pause_edge;
  stage_t        state;
  logic          timer_zero, timer_load, timer_en;
  logic [FW-1:0] timer_value;
  logic          intro_done, end_done, battle_decided, go_intro;
  logic          player_takes, npc_takes;
  logic [1:0]    battle_result;

  // Core logic leaves reset two clocks after release; the button flops run meanwhile,
  // so a button already held at release is seen as a level, not an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rst_sync <= 2'b00;
      fight_q  <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      fight_q  <= Fight;
      pause_q  <= Pause;
    end
  end

  assign core_rst_n = rst_sync[1];
  assign fight_edge = Fight & ~fight_q;
  assign pause_edge = Pause & ~pause_q;

  always_comb begin
    intro_done     = (state == ST_INTRO) && timer_zero;
    end_done       = (state == ST_ROUND_END) && timer_zero;
    battle_decided = (state == ST_BATTLE) && (Player_Dead || NPC_Dead || timer_zero);
    player_takes   = (player_wins == 4'(ROUNDS_TO_WIN));
    npc_takes      = (npc_wins == 4'(ROUNDS_TO_WIN));

    if (Player_Dead && NPC_Dead)  battle_result = RES_DRAW;
    else if (NPC_Dead)            battle_result = RES_PLAYER;
    else if (Player_Dead)         battle_result = RES_NPC;
    else if (Player_HP > NPC_HP)  battle_result = RES_PLAYER;
    else if (Player_HP < NPC_HP)  battle_result = RES_NPC;
    else                          battle_result = RES_DRAW;

    go_intro   = ((state == ST_START) && fight_edge) || (end_done && !player_takes && !npc_takes);
    timer_load = go_intro || intro_done || battle_decided;
    timer_value = '0;
    if (go_intro)            timer_value = FW'(INTRO_FRAMES);
    else if (intro_done)     timer_value = FW'(ROUND_FRAMES);
    else if (battle_decided) timer_value = FW'(END_FRAMES);
    // Leaving BATTLE for PAUSED must not consume a frame of the round.
    timer_en = (state == ST_INTRO) || (state == ST_ROUND_END) ||
               ((state == ST_BATTLE) && !pause_edge);
  end

  frame_timer #(.W(FW)) u_timer (
    .clk        (Clk),
    .rst_n      (core_rst_n),
    .clr        (Restart),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (timer_value),
    .count      (frames_left),
    .zero       (timer_zero)
  );

  always_ff @(posedge Clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state        <= ST_START;
      round_num    <= 8'd0;
      player_wins  <= 4'd0;
      npc_wins     <= 4'd0;
      round_result <= RES_NONE;
      round_reset  <= 1'b0;
    end else if (Restart) begin
      state        <= ST_START;
      round_num    <= 8'd0;
      player_wins  <= 4'd0;
      npc_wins     <= 4'd0;
      round_result <= RES_NONE;
      round_reset  <= 1'b0;
    end else begin
      round_reset <= go_intro;
      case (state)
        ST_START: begin
          if (fight_edge) begin
            state        <= ST_INTRO;
            round_num    <= 8'd1;
            player_wins  <= 4'd0;
            npc_wins     <= 4'd0;
            round_result <= RES_NONE;
          end
        end
        ST_INTRO: begin
          if (timer_zero) state <= ST_BATTLE;
        end
        ST_BATTLE: begin
          if (battle_decided) begin
            state        <= ST_ROUND_END;
            round_result <= battle_result;
            if (battle_result == RES_PLAYER) player_wins <= player_wins + 4'd1;
            else if (battle_result == RES_NPC) npc_wins <= npc_wins + 4'd1;
          end else if (pause_edge) begin
            state <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (pause_edge) state <= ST_BATTLE;
        end
        ST_ROUND_END: begin
          if (timer_zero) begin
            if (player_takes) begin
              state <= ST_MATCH_WIN;
            end else if (npc_takes) begin
              state <= ST_MATCH_LOSE;
            end else begin
              state <= ST_INTRO;
              if (round_num != 8'hFF) round_num <= round_num + 8'd1;
            end
          end
        end
        ST_MATCH_WIN, ST_MATCH_LOSE: begin
          if (fight_edge) begin
            state        <= ST_START;
            round_num    <= 8'd0;
            player_wins  <= 4'd0;
            npc_wins     <= 4'd0;
            round_result <= RES_NONE;
          end
        end
        default: state <= ST_START;
      endcase
    end
  end

  assign start_l     = (state == ST_START);
  assign intro_l     = (state == ST_INTRO);
  assign game_l      = (state == ST_BATTLE);
  assign pause_l     = (state == ST_PAUSED);
  assign round_end_l = (state == ST_ROUND_END);
  assign win_l       = (state == ST_MATCH_WIN);
  assign lose_l      = (state == ST_MATCH_LOSE);

endmodule

// File: tb/tb_match_control.sv
// Directed test-plan scenarios plus random play, checked each cycle against a match model.
module tb_match_control;

  localparam int RTW = 2;
  localparam int IFR = 3;
  localparam int RFR = 10;
  localparam int EFR = 2;
  localparam int FW  = 4;

  localparam int P_START = 0, P_INTRO = 1, P_BATTLE = 2, P_PAUSED = 3,
                 P_END = 4, P_WIN = 5, P_LOSE = 6;

  logic Clk = 1'b0, Reset = 1'b1, Restart = 1'b0, Fight = 1'b0, Pause = 1'b0;
  logic Player_Dead = 1'b0, NPC_Dead = 1'b0;
  logic [7:0] Player_HP = 8'd100, NPC_HP = 8'd100;
  logic start_l, intro_l, game_l, pause_l, round_end_l, win_l, lose_l, round_reset;
  logic [7:0] round_num;
  logic [3:0] player_wins, npc_wins;
  logic [1:0] round_result;
  logic [FW-1:0] frames_left;

  match_control #(
    .ROUNDS_TO_WIN(RTW), .INTRO_FRAMES(IFR), .ROUND_FRAMES(RFR),
    .END_FRAMES(EFR), .HP_W(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Restart(Restart), .Fight(Fight), .Pause(Pause),
    .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead),
    .Player_HP(Player_HP), .NPC_HP(NPC_HP),
    .start_l(start_l), .intro_l(intro_l), .game_l(game_l), .pause_l(pause_l),
    .round_end_l(round_end_l), .win_l(win_l), .lose_l(lose_l),
    .round_reset(round_reset), .round_num(round_num),
    .player_wins(player_wins), .npc_wins(npc_wins),
    .round_result(round_result), .frames_left(frames_left)
  );

  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rr_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- match model ----------------
  int m_phase = P_START, m_left = 0, m_pw = 0, m_nw = 0, m_res = 0, m_rnd = 0;
  bit m_rr = 1'b0, m_fq = 1'b0, m_pq = 1'b0;
  int m_sync = 0;

  task automatic m_clear();
    m_phase = P_START; m_left = 0; m_pw = 0; m_nw = 0; m_res = 0; m_rnd = 0; m_rr = 1'b0;
  endtask

  task automatic m_enter_intro();
    m_phase = P_INTRO; m_left = IFR; m_rr = 1'b1;
  endtask

  task automatic m_step(input bit fe, input bit pe);
    int w;
    m_rr = 1'b0;
    if (Restart) begin
      m_clear();
      return;
    end
    case (m_phase)
      P_START: if (fe) begin
        m_pw = 0; m_nw = 0; m_res = 0; m_rnd = 1; m_enter_intro();
      end
      P_INTRO: if (m_left == 0) begin m_phase = P_BATTLE; m_left = RFR; end
               else m_left--;
      P_BATTLE: begin
        if (Player_Dead || NPC_Dead || m_left == 0) begin
          if (Player_Dead && NPC_Dead) w = 3;
          else if (NPC_Dead) w = 1;
          else if (Player_Dead) w = 2;
          else if (Player_HP > NPC_HP) w = 1;
          else if (Player_HP < NPC_HP) w = 2;
          else w = 3;
          m_res = w;
          if (w == 1) m_pw++;
          if (w == 2) m_nw++;
          m_phase = P_END; m_left = EFR;
        end else if (pe) m_phase = P_PAUSED;
        else m_left--;
      end
      P_PAUSED: if (pe) m_phase = P_BATTLE;
      P_END: begin
        if (m_left != 0) m_left--;
        else if (m_pw == RTW) m_phase = P_WIN;
        else if (m_nw == RTW) m_phase = P_LOSE;
        else begin
          m_rnd = (m_rnd < 255) ? m_rnd + 1 : 255;
          m_enter_intro();
        end
      end
      default: if (fe) m_clear();
    endcase
  endtask

  always @(posedge Clk or negedge Reset) begin
    bit fe, pe;
    if (!Reset) begin
      m_clear(); m_fq = 1'b0; m_pq = 1'b0; m_sync = 0;
    end else begin
      fe = Fight && !m_fq;
      pe = Pause && !m_pq;
      m_fq = Fight;
      m_pq = Pause;
      if (m_sync < 2) m_sync++;
      else m_step(fe, pe);
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge Clk) begin
    logic [6:0] exp_flags;
    if (chk_en) begin
      exp_flags = 7'b1000000 >> m_phase;
      check("stage_flags", int'({start_l, intro_l, game_l, pause_l, round_end_l, win_l, lose_l}),
            int'(exp_flags));
      check("round_reset", int'(round_reset), int'(m_rr));
      check("round_num", int'(round_num), m_rnd);
      check("player_wins", int'(player_wins), m_pw);
      check("npc_wins", int'(npc_wins), m_nw);
      check("round_result", int'(round_result), m_res);
      check("frames_left", int'(frames_left), m_left);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
      if (round_reset) rr_cnt++;
    end
  endtask

  function automatic bit flag(input int sel);
    logic [6:0] v;
    v = {start_l, intro_l, game_l, pause_l, round_end_l, win_l, lose_l};
    return v[6 - sel];
  endfunction

  task automatic wait_for(input string name, input int sel, input int limit);
    int k;
    k = 0;
    while (!flag(sel) && k < limit) begin
      cyc(1);
      k++;
    end
    check(name, int'(flag(sel)), 1);
  endtask

  task automatic fight_pulse();
    Fight = 1'b1; cyc(1); Fight = 1'b0;
  endtask

  initial begin
    int n;
    #2 Reset = 1'b0;
    chk_en = 1'b1;
    cyc(2);
    check("reset_start_l", int'(start_l), 1);
    check("reset_frames", int'(frames_left), 0);
    Reset = 1'b1;
    cyc(3);

    // Scenario 1: player wins 2-0 by NPC deaths
    rr_cnt = 0;
    fight_pulse();
    wait_for("s1_intro", P_INTRO, 5);
    n = 0;
    while (intro_l && n < 20) begin cyc(1); n++; end
    check("s1_intro_len", n, IFR + 1);
    NPC_Dead = 1'b1; cyc(1); NPC_Dead = 1'b0;
    wait_for("s1_intro2", P_INTRO, 20);
    check("s1_round2", int'(round_num), 2);
    wait_for("s1_battle2", P_BATTLE, 20);
    NPC_Dead = 1'b1; cyc(1); NPC_Dead = 1'b0;
    wait_for("s1_win", P_WIN, 20);
    check("s1_pwins", int'(player_wins), 2);
    check("s1_rr_pulses", rr_cnt, 2);
    fight_pulse();
    cyc(1);
    check("s1_back_start", int'(start_l), 1);

    // Scenario 2: timeout, NPC has more health
    Player_HP = 8'd20; NPC_HP = 8'd50;
    fight_pulse();
    wait_for("s2_battle", P_BATTLE, 10);
    wait_for("s2_end", P_END, 20);
    check("s2_result", int'(round_result), 2);
    check("s2_nwins", int'(npc_wins), 1);

    // Scenario 3: double KO is a draw
    Player_HP = 8'd100; NPC_HP = 8'd100;
    wait_for("s3_battle", P_BATTLE, 20);
    Player_Dead = 1'b1; NPC_Dead = 1'b1; cyc(1); Player_Dead = 1'b0; NPC_Dead = 1'b0;
    wait_for("s3_end", P_END, 5);
    check("s3_result", int'(round_result), 3);
    check("s3_pwins", int'(player_wins), 0);
    check("s3_nwins", int'(npc_wins), 1);
    wait_for("s3_intro", P_INTRO, 10);
    check("s3_round", int'(round_num), 3);

    // Scenario 4: pause freezes timer and ignores deaths
    wait_for("s4_battle", P_BATTLE, 10);
    n = 0;
    while (frames_left != 4'd6 && n < 20) begin cyc(1); n++; end
    check("s4_at6", int'(frames_left), 6);
    Pause = 1'b1; cyc(1);
    check("s4_paused", int'(pause_l), 1);
    NPC_Dead = 1'b1; cyc(20);
    check("s4_still_paused", int'(pause_l), 1);
    check("s4_frozen", int'(frames_left), 6);
    check("s4_no_score", int'(player_wins), 0);
    NPC_Dead = 1'b0; Pause = 1'b0; cyc(1);
    Pause = 1'b1; cyc(1);
    check("s4_resumed", int'(game_l), 1);
    check("s4_resume_frames", int'(frames_left), 6);
    Pause = 1'b0; NPC_Dead = 1'b1; cyc(1); NPC_Dead = 1'b0;
    check("s4_end", int'(round_end_l), 1);
    check("s4_pwins", int'(player_wins), 1);

    // Scenario 5: restart mid-ROUND_END at 1-1
    cyc(1);
    Restart = 1'b1; cyc(1); Restart = 1'b0;
    check("s5_start", int'(start_l), 1);
    check("s5_round", int'(round_num), 0);
    check("s5_nwins", int'(npc_wins), 0);
    check("s5_frames", int'(frames_left), 0);

    // Scenario 6: async reset mid-INTRO, Fight held through release
    fight_pulse();
    wait_for("s6_intro", P_INTRO, 5);
    cyc(1);
    #2;
    Reset = 1'b0; Fight = 1'b1;
    #1;
    check("s6_async_start", int'(start_l), 1);
    check("s6_async_intro", int'(intro_l), 0);
    check("s6_async_round", int'(round_num), 0);
    cyc(3);
    Reset = 1'b1;
    cyc(8);
    check("s6_held_fight", int'(start_l), 1);
    Fight = 1'b0;
    cyc(2);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) Fight = ~Fight;
      if ($urandom_range(0, 7) == 0) Pause = ~Pause;
      Player_Dead = ($urandom_range(0, 24) == 0);
      NPC_Dead    = ($urandom_range(0, 24) == 0);
      Restart     = ($urandom_range(0, 399) == 0);
      Player_HP   = 8'($urandom_range(0, 3) * 10);
      NPC_HP      = 8'($urandom_range(0, 3) * 10);
      cyc(1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
